// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard.
// Latency: n/a (types only).
// Backpressure: n/a.
package fwd_pkg;

  // Entry fields are sized for the widest supported configuration.
  // Narrower register/latency fields are zero-extended on write and compare.
  localparam int FWD_RD_W  = 8;
  localparam int FWD_LAT_W = 4;

  // Forward select 0 means "read the register file".
  localparam int FWD_SEL_RF = 0;

  // Stage index at which a producer's result becomes forwardable.
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

  typedef struct packed {
    logic                 valid;
    logic [FWD_RD_W-1:0]  rd;
    logic [FWD_LAT_W-1:0] lat;
  } fwd_entry_t;

  // Select width: one code per tracked stage, plus the register file.
  function automatic int fwd_sel_w(input int num_stages);
    return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-stage request and forward/stall response bundle of the scoreboard.
// Latency: responses are combinational from the requests and scoreboard state.
// Backpressure: hazard_stall_o holds the ID instruction; hold_i freezes the scoreboard.
// Ports: master = core pipeline (drives ID fields, hold, flush),
//        slave  = scoreboard (drives fwd_sel_o, hazard_stall_o, stall_cnt_o).
interface fwd_hazard_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int LAT_W      = 2,
  parameter int CNT_W      = 32
);
  localparam int SEL_W = fwd_sel_w(NUM_STAGES);

  logic                      id_valid_i;
  logic [REG_AW-1:0]         id_rd_i;
  logic                      id_regwrite_i;
  logic [LAT_W-1:0]          id_lat_i;
  logic [NUM_SRC*REG_AW-1:0] id_rs_i;
  logic [NUM_SRC-1:0]        id_rs_used_i;
  logic                      hold_i;
  logic                      flush_i;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
  logic                      hazard_stall_o;
  logic [CNT_W-1:0]          stall_cnt_o;

  modport master (
    output id_valid_i, id_rd_i, id_regwrite_i, id_lat_i, id_rs_i, id_rs_used_i,
           hold_i, flush_i,
    input  fwd_sel_o, hazard_stall_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rd_i, id_regwrite_i, id_lat_i, id_rs_i, id_rs_used_i,
           hold_i, flush_i,
    output fwd_sel_o, hazard_stall_o, stall_cnt_o
  );

endinterface

// File: rtl/fwd_hazard_scoreboard_src_match.sv
// Youngest-producer priority match for one ID source operand.
// Latency: purely combinational.
// Backpressure: none; not_ready feeds the stall decision in the parent.
// Ports: rs/used = source operand, entries = shadow pipeline (0 = EX),
//        sel = 0 for regfile or k+1 for entry k, not_ready = producer not forwardable yet.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int SEL_W      = 2
) (
  input  logic [REG_AW-1:0]                 rs,
  input  logic                              used,
  input  fwd_entry_t [NUM_STAGES-1:0]       entries,
  output logic [SEL_W-1:0]                  sel,
  output logic                              not_ready
);

  logic found;

  // Scanning from entry 0 upwards and latching the first hit gives the
  // youngest producer; older writes to the same register are shadowed.
  always_comb begin
    sel       = SEL_W'(FWD_SEL_RF);
    not_ready = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (!found && used && (rs != '0) && entries[k].valid &&
          (entries[k].rd == FWD_RD_W'(rs))) begin
        found     = 1'b1;
        sel       = SEL_W'(k + 1);
        not_ready = (k < int'(entries[k].lat));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select and hazard stall from a shadow pipeline of in-flight writes.
// Latency: sel/stall combinational from state + ID inputs; shadow pipeline advances 1/clk.
// Backpressure: hold_i freezes entries and counter; a stall injects a bubble into EX.
// Ports: clk, rst_n (async active-low), id (slave side of fwd_hazard_scoreboard_if).
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int LAT_W      = 2,
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fwd_hazard_scoreboard_if.slave    id
);

  localparam int SEL_W = fwd_sel_w(NUM_STAGES);

  fwd_entry_t [NUM_STAGES-1:0] entries;
  fwd_entry_t                  new_entry;
  logic [NUM_SRC-1:0]          not_ready;
  logic [NUM_SRC*SEL_W-1:0]    sel_flat;
  logic                        stall;
  logic [CNT_W-1:0]            stall_cnt;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_match #(
      .NUM_STAGES (NUM_STAGES),
      .REG_AW     (REG_AW),
      .SEL_W      (SEL_W)
    ) u_match (
      .rs        (id.id_rs_i[s*REG_AW +: REG_AW]),
      .used      (id.id_rs_used_i[s]),
      .entries   (entries),
      .sel       (sel_flat[s*SEL_W +: SEL_W]),
      .not_ready (not_ready[s])
    );
  end

  // Flush squashes the ID instruction, so it also cancels its stall.
  assign stall = id.id_valid_i & ~id.flush_i & (|not_ready);

  // x0 writes and non-writing instructions enter as bubbles so they can never
  // shadow an older real producer of the same register.
  always_comb begin
    new_entry = '0;
    if (id.id_valid_i && !id.flush_i && !stall &&
        id.id_regwrite_i && (id.id_rd_i != '0)) begin
      new_entry.valid = 1'b1;
      new_entry.rd    = FWD_RD_W'(id.id_rd_i);
      new_entry.lat   = (int'(id.id_lat_i) > NUM_STAGES - 1) ?
                        FWD_LAT_W'(NUM_STAGES - 1) : FWD_LAT_W'(id.id_lat_i);
    end
  end

  // The last entry simply drops off: the regfile writes before it is read,
  // so a retiring producer is already visible through select 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries   <= '0;
      stall_cnt <= '0;
    end else if (!id.hold_i) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) begin
        entries[k] <= entries[k-1];
      end
      entries[0] <= new_entry;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign id.fwd_sel_o      = sel_flat;
  assign id.hazard_stall_o = stall;
  assign id.stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: directed scenarios plus random traffic.
// Reference model keeps in-flight writes in a queue (youngest at the front).
// A narrow counter width lets saturation be reached quickly.
module tb_fwd_hazard_scoreboard;
  import fwd_pkg::*;

  localparam int NSRC = 2;
  localparam int NST  = 3;
  localparam int AW   = 5;
  localparam int LW   = 2;
  localparam int CW   = 4;
  localparam int SW   = fwd_sel_w(NST);
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_scoreboard_if #(
    .NUM_SRC(NSRC), .NUM_STAGES(NST), .REG_AW(AW), .LAT_W(LW), .CNT_W(CW)
  ) bus ();

  fwd_hazard_scoreboard #(
    .NUM_SRC(NSRC), .NUM_STAGES(NST), .REG_AW(AW), .LAT_W(LW), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .id    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {bit v; int rd; int lat;} slot_t;
  slot_t pipe[$];
  int    m_cnt;
  int    m_sel[NSRC];
  bit    m_stall;

  function automatic int dut_sel(input int s);
    return int'(bus.fwd_sel_o[s*SW +: SW]);
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (NST) pipe.push_back('{v: 1'b0, rd: 0, lat: 0});
    m_cnt = 0;
  endtask

  task automatic model_eval();
    bit any_wait;
    int rs;
    any_wait = 0;
    for (int s = 0; s < NSRC; s++) begin
      m_sel[s] = 0;
      rs = int'(bus.id_rs_i[s*AW +: AW]);
      if (bus.id_rs_used_i[s] && rs != 0) begin
        for (int i = 0; i < NST; i++) begin
          if (pipe[i].v && pipe[i].rd == rs) begin
            m_sel[s] = i + 1;
            if (i < pipe[i].lat) any_wait = 1;
            break;
          end
        end
      end
    end
    m_stall = bus.id_valid_i && !bus.flush_i && any_wait;
  endtask

  task automatic model_step();
    slot_t n;
    if (bus.hold_i) return;
    model_eval();
    if (m_stall && m_cnt < CMAX) m_cnt++;
    n = '{v: 1'b0, rd: 0, lat: 0};
    if (bus.id_valid_i && !bus.flush_i && !m_stall && bus.id_regwrite_i && bus.id_rd_i != 0) begin
      n.v   = 1'b1;
      n.rd  = int'(bus.id_rd_i);
      n.lat = (int'(bus.id_lat_i) > NST - 1) ? NST - 1 : int'(bus.id_lat_i);
    end
    pipe.push_front(n);
    void'(pipe.pop_back());
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int rd, input bit rw, input int lat,
                       input int rs0, input int rs1, input bit [1:0] used,
                       input bit hold, input bit flush);
    bus.id_valid_i    = v;
    bus.id_rd_i       = AW'(rd);
    bus.id_regwrite_i = rw;
    bus.id_lat_i      = LW'(lat);
    bus.id_rs_i       = {AW'(rs1), AW'(rs0)};
    bus.id_rs_used_i  = used;
    bus.hold_i        = hold;
    bus.flush_i       = flush;
  endtask

  // Compare at the falling edge, then advance DUT and model together.
  task automatic cyc();
    @(negedge clk);
    model_eval();
    for (int s = 0; s < NSRC; s++) chk($sformatf("sel%0d", s), dut_sel(s), m_sel[s]);
    chk("stall", int'(bus.hazard_stall_o), int'(m_stall));
    chk("cnt", int'(bus.stall_cnt_o), m_cnt);
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Assert reset mid-cycle and check that outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_sel0"}, dut_sel(0), 0);
    chk({tag, "_sel1"}, dut_sel(1), 0);
    chk({tag, "_stall"}, int'(bus.hazard_stall_o), 0);
    chk({tag, "_cnt"}, int'(bus.stall_cnt_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_sel0", dut_sel(0), 0);
    chk("rst_stall", int'(bus.hazard_stall_o), 0);
    chk("rst_cnt", int'(bus.stall_cnt_o), 0);
    rst_n = 1'b1;

    // 1: ALU forwarding walks down the stages, then falls back to the regfile.
    drive(1, 5, 1, LAT_ALU, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 0, 0, 0, 5, 0, 2'b01, 0, 0);
    #1 chk("t1_sel_ex", dut_sel(0), 1); chk("t1_nostall", int'(bus.hazard_stall_o), 0);
    cyc();
    drive(0, 0, 0, 0, 5, 0, 2'b01, 0, 0);
    #1 chk("t1_sel_mem", dut_sel(0), 2); cyc();
    #1 chk("t1_sel_wb", dut_sel(0), 3); cyc();
    #1 chk("t1_sel_rf", dut_sel(0), 0); cyc();

    // 2: load-use costs exactly one stall cycle.
    async_reset("t2_rst");
    drive(1, 7, 1, LAT_LOAD, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 7, 2'b10, 0, 0);
    #1 chk("t2_stall", int'(bus.hazard_stall_o), 1); cyc();
    #1 chk("t2_unstall", int'(bus.hazard_stall_o), 0);
    chk("t2_sel_mem", dut_sel(1), 2);
    chk("t2_cnt", int'(bus.stall_cnt_o), 1);
    cyc();

    // 3: two producers of x3, the younger wins for both sources.
    drive(1, 3, 1, 0, 0, 0, 2'b00, 0, 0); cyc(); cyc();
    drive(1, 0, 0, 0, 3, 3, 2'b11, 0, 0);
    #1 chk("t3_sel0", dut_sel(0), 1); chk("t3_sel1", dut_sel(1), 1); cyc();

    // 4: x0 is never tracked; unused sources never forward.
    drive(1, 9, 1, 0, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 0, 1, 0, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 9, 2'b01, 0, 0);
    #1 chk("t4_x0", dut_sel(0), 0); chk("t4_unused", dut_sel(1), 0);
    chk("t4_stall", int'(bus.hazard_stall_o), 0);
    drive(1, 0, 0, 0, 0, 9, 2'b10, 0, 0);
    #1 chk("t4_used", dut_sel(1), 2); cyc();

    // 5: hold freezes a pending load-use, then flush clears it.
    async_reset("t5_rst");
    drive(1, 7, 1, LAT_LOAD, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 0, 0, 0, 7, 0, 2'b01, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_hold_stall", int'(bus.hazard_stall_o), 1);
      chk("t5_hold_cnt", int'(bus.stall_cnt_o), 0);
      chk("t5_hold_sel", dut_sel(0), 1);
      cyc();
    end
    drive(1, 0, 0, 0, 7, 0, 2'b01, 0, 1);
    #1 chk("t5_flush_stall", int'(bus.hazard_stall_o), 0); cyc();
    drive(0, 0, 0, 0, 7, 0, 2'b01, 0, 0);
    #1 chk("t5_bubble_sel", dut_sel(0), 2); chk("t5_cnt", int'(bus.stall_cnt_o), 0); cyc();

    // 6: counter saturates, then async reset clears everything mid-stall.
    async_reset("t6_rst0");
    for (int i = 0; i < 10; i++) begin
      drive(1, 7, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
      drive(1, 0, 0, 0, 7, 0, 2'b01, 0, 0); cyc(); cyc(); cyc();
    end
    #1 chk("t6_sat", int'(bus.stall_cnt_o), CMAX);
    drive(1, 7, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 0, 0, 0, 7, 0, 2'b01, 0, 0);
    #1 chk("t6_pre_stall", int'(bus.hazard_stall_o), 1);
    async_reset("t6_rst");

    // Random traffic over a small register window to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
            2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      else cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
